// File: rtl/fibo_dp_arbiter.sv
// Two-requester datapath arbiter: the Fibonacci sequencer and the host port share one datapath.
// Optional grant timeout is enabled by defining FIBO_ARB_TIMEOUT_EN.
module fibo_dp_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [10:0] ctrl0_i,
    input  logic [10:0] ctrl1_i,
    input  logic        zero_flag,
    output logic        gnt0,
    output logic        gnt1,
    output logic [2:0]  alu_opcode,
    output logic [1:0]  rd_addr1,
    output logic [1:0]  rd_addr2,
    output logic [1:0]  wrt_addr,
    output logic        wrt_en,
    output logic        load_data,
    output logic        zero_flag0,
    output logic        zero_flag1,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 8;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("fibo_dp_arbiter: TIMEOUT_CYC must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt;

`ifdef FIBO_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] EXPIRE_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic             expired;
    logic             force_sw;
    logic             timeout_q;

    // Threshold is ">=" so a requester arriving late in a long grant still waits at most one more cycle.
    assign expired = (cnt >= EXPIRE_CNT);
`endif

    // Next-state: release hands over directly, ties go to the requester not served last.
    always_comb begin
        state_nxt = state;
`ifdef FIBO_ARB_TIMEOUT_EN
        force_sw  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last_gnt ? G0 : G1;
                end else if (req0) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    state_nxt = req1 ? G1 : IDLE;
                end
`ifdef FIBO_ARB_TIMEOUT_EN
                else if (req1 && expired) begin
                    state_nxt = G1;
                    force_sw  = 1'b1;
                end
`endif
            end
            G1: begin
                if (!req1) begin
                    state_nxt = req0 ? G0 : IDLE;
                end
`ifdef FIBO_ARB_TIMEOUT_EN
                else if (req0 && expired) begin
                    state_nxt = G0;
                    force_sw  = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin pointer, which follows every grant entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == G0 && state != G0) begin
                last_gnt <= 1'b0;
            end else if (state_nxt == G1 && state != G1) begin
                last_gnt <= 1'b1;
            end
        end
    end

`ifdef FIBO_ARB_TIMEOUT_EN
    // Grant-length counter: zero on the entry cycle, saturates so it never wraps back under the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_sw;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != IDLE && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    logic [CTRL_W-1:0] ctrl_sel;

    // Only the granted requester's controls reach the datapath; idle drives a no-op.
    always_comb begin
        ctrl_sel = '0;
        unique case (state)
            G0:      ctrl_sel = ctrl0_i;
            G1:      ctrl_sel = ctrl1_i;
            default: ctrl_sel = '0;
        endcase
    end

    assign {alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data} = ctrl_sel;

    assign gnt0       = (state == G0);
    assign gnt1       = (state == G1);
    assign busy       = gnt0 | gnt1;
    assign zero_flag0 = zero_flag & gnt0;
    assign zero_flag1 = zero_flag & gnt1;

endmodule

// File: tb/tb_fibo_dp_arbiter.sv
// Randomized and directed bench for fibo_dp_arbiter against a behavioural owner/pointer model.
module tb_fibo_dp_arbiter;

    localparam int unsigned TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [10:0] ctrl0_i, ctrl1_i;
    logic        zero_flag;
    logic        gnt0, gnt1;
    logic [2:0]  alu_opcode;
    logic [1:0]  rd_addr1, rd_addr2, wrt_addr;
    logic        wrt_en, load_data;
    logic        zero_flag0, zero_flag1;
    logic        busy, timeout;

    int checks   = 0;
    int failures = 0;

    // Model: owner of the datapath (-1 none), who was served last, cycles held, forced-switch flag.
    int owner    = -1;
    int last     = 1;
    int held     = 0;
    bit forced   = 1'b0;

    fibo_dp_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .ctrl0_i    (ctrl0_i),
        .ctrl1_i    (ctrl1_i),
        .zero_flag  (zero_flag),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .alu_opcode (alu_opcode),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .wrt_addr   (wrt_addr),
        .wrt_en     (wrt_en),
        .load_data  (load_data),
        .zero_flag0 (zero_flag0),
        .zero_flag1 (zero_flag1),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit r [2];
        int nxt;
        bit f;
        r[0] = req0;
        r[1] = req1;
        f    = 1'b0;
        if (!rst_n) begin
            owner = -1;
            last  = 1;
            held  = 0;
            forced = 1'b0;
        end else begin
            nxt = owner;
            if (owner < 0) begin
                if (r[0] && r[1]) nxt = 1 - last;
                else if (r[0])    nxt = 0;
                else if (r[1])    nxt = 1;
            end else if (!r[owner]) begin
                nxt = r[1 - owner] ? 1 - owner : -1;
            end else begin
`ifdef FIBO_ARB_TIMEOUT_EN
                if (r[1 - owner] && held >= int'(TO_CYC) - 1) begin
                    nxt = 1 - owner;
                    f   = 1'b1;
                end
`endif
            end
            if (nxt != owner) begin
                held = 0;
                if (nxt >= 0) last = nxt;
            end else if (owner >= 0) begin
                held++;
            end
            owner  = nxt;
            forced = f;
        end
    endtask

    task automatic check_all();
        logic [10:0] exp_ctrl;
        exp_ctrl = (owner == 0) ? ctrl0_i : (owner == 1) ? ctrl1_i : 11'h000;
        check_eq("gnt0", 32'(gnt0), 32'(owner == 0));
        check_eq("gnt1", 32'(gnt1), 32'(owner == 1));
        check_eq("busy", 32'(busy), 32'(owner >= 0));
        check_eq("timeout", 32'(timeout), 32'(forced));
        check_eq("ctrl", 32'({alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data}), 32'(exp_ctrl));
        check_eq("zf0", 32'(zero_flag0), 32'(zero_flag && owner == 0));
        check_eq("zf1", 32'(zero_flag1), 32'(zero_flag && owner == 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        ctrl0_i = 11'h000; ctrl1_i = 11'h000; zero_flag = 1'b0;

        // Reset held with both requests up, then release.
        tick();
        tick();
        check_eq("rst_gnt0", 32'(gnt0), 32'd0);
        check_eq("rst_gnt1", 32'(gnt1), 32'd0);
        check_eq("rst_alu", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel_gnt0", 32'(gnt0), 32'd1);

        // Mux selection while G0 is granted.
        ctrl0_i = 11'h5A5; ctrl1_i = 11'h7FF; zero_flag = 1'b1;
        tick();
        check_eq("mux_op", 32'(alu_opcode), 32'h5);
        check_eq("mux_we", 32'(wrt_en), 32'd0);
        check_eq("mux_ld", 32'(load_data), 32'd1);
        check_eq("mux_zf0", 32'(zero_flag0), 32'd1);
        check_eq("mux_zf1", 32'(zero_flag1), 32'd0);

        // Round-robin handover without an idle bubble, then tie after G1.
        zero_flag = 1'b0;
        do_reset(1);
        tick(); tick(); tick();
        check_eq("rr_g0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick();
        check_eq("rr_g1", 32'(gnt1), 32'd1);
        check_eq("rr_busy", 32'(busy), 32'd1);
        req1 = 1'b0;
        tick();
        check_eq("rr_idle", 32'(busy), 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_eq("rr_tie", 32'(gnt0), 32'd1);

        // Reset in the middle of a G1 grant driving wrt_en.
        req0 = 1'b0; req1 = 1'b1; ctrl1_i = 11'h002;
        do_reset(1);
        tick();
        check_eq("mr_g1", 32'(gnt1), 32'd1);
        check_eq("mr_we1", 32'(wrt_en), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("mr_gnt1", 32'(gnt1), 32'd0);
        check_eq("mr_we0", 32'(wrt_en), 32'd0);
        rst_n = 1'b1; req0 = 1'b1;
        tick();
        check_eq("mr_tie", 32'(gnt0), 32'd1);

        // Long G0 grant with req1 waiting.
        req1 = 1'b0;
        do_reset(1);
        tick();
        req1 = 1'b1;
        for (int i = 0; i < int'(TO_CYC) - 1; i++) begin
            tick();
            check_eq("to_hold", 32'(gnt0), 32'd1);
        end
        tick();
`ifdef FIBO_ARB_TIMEOUT_EN
        check_eq("to_gnt1", 32'(gnt1), 32'd1);
        check_eq("to_pulse", 32'(timeout), 32'd1);
        tick();
        check_eq("to_pulse_end", 32'(timeout), 32'd0);
`else
        check_eq("to_gnt0", 32'(gnt0), 32'd1);
        check_eq("to_none", 32'(timeout), 32'd0);
`endif

        // Single-cycle req1 pulse from idle.
        req0 = 1'b0; req1 = 1'b0;
        do_reset(1);
        tick();
        req1 = 1'b1;
        tick();
        check_eq("pl_g1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        tick();
        check_eq("pl_idle", 32'(gnt1), 32'd0);
        tick();
        check_eq("pl_stay", 32'(busy), 32'd0);

        // Random traffic with sticky requests and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req0 = 1'($urandom);
            if ($urandom_range(0, 3) == 0) req1 = 1'($urandom);
            ctrl0_i   = 11'($urandom);
            ctrl1_i   = 11'($urandom);
            zero_flag = 1'($urandom);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
